// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: single outstanding req/ack handshake with same-cycle data.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: owns the PC, fetches over imem, buffers {pc,inst} for IF/ID.
// Optional FETCH_PERF_EN macro adds perf_fetch/perf_bubble counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stop,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic                   if_valid,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_pc4,
    output logic [31:0]            if_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetch,
    output logic [31:0]            perf_bubble
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] Nop  = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       drain_addr_q, drain_addr_d;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [31:0]       pc_mem   [FIFO_DEPTH];
    logic [31:0]       inst_mem [FIFO_DEPTH];

    logic              req;
    logic [31:0]       addr;
    logic              push;
    logic              pop;
    logic              has_room;

    // Low address bits of a redirect target are discarded by design.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign has_room = (count_q < CntW'(FIFO_DEPTH));
    assign if_valid = (count_q != '0);
    assign pop      = if_valid && !stop && !redirect;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        req          = 1'b0;
        addr         = pc_q;
        push         = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                req = has_room;
                if (redirect) begin
                    // An unacked request must still complete; remember its address.
                    if (req && !imem.ack) begin
                        state_d      = StDrain;
                        drain_addr_d = pc_q;
                    end
                end else if (req && imem.ack) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            StDrain: begin
                req  = 1'b1;
                addr = drain_addr_q;
                if (imem.ack) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    assign imem.req  = req;
    assign imem.addr = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= pc_q;
            inst_mem[wr_ptr_q] <= imem.rdata;
        end
    end

    always_comb begin
        if_pc   = '0;
        if_pc4  = '0;
        if_inst = Nop;
        if (if_valid) begin
            if_pc   = pc_mem[rd_ptr_q];
            if_pc4  = pc_mem[rd_ptr_q] + 32'd4;
            if_inst = inst_mem[rd_ptr_q];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (push) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (!if_valid && !stop) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetch  = perf_fetch_q;
    assign perf_bubble = perf_bubble_q;
`endif

    // A pending fetch must hold its address until acknowledged.
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (imem.req && !imem.ack) |=> (imem.req && $stable(imem.addr)));

endmodule
